count_wrap_monitor: RTL and testbench
=====================================

Name: count_wrap_monitor

Overview:
- Downstream consumer of the 4-bit free-running counter (first_counter) output.
- Samples counter value and enable every clock, detects wrap-around (F->0) and threshold hits, and counts wraps.
- Signals completion after a programmed number of wraps.
- Used as the run-length/terminal-event stage after the counter in the stimulus top level.

Parameters:
- CNT_W, 4, width of incoming counter value
- WRAP_W, 8, width of wrap_count
- TARGET_WRAPS, 4, wraps in RUN before done asserts (1..2^WRAP_W-1)

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high; all state cleared on the clock edge where it is high
- enable  input  1  same enable driven to the upstream counter
- counter_in  input  CNT_W  upstream counter_out
- arm  input  1  single-cycle request to start a monitoring run
- threshold  input  CNT_W  match value, latched on accepted arm
- busy  output  1  high in ARMED or RUN
- match_pulse  output  1  one-cycle pulse when counter_in first equals latched threshold
- wrap_pulse  output  1  one-cycle pulse per detected wrap, any state
- wrap_count  output  WRAP_W  wraps seen in current run
- done  output  1  high in DONE
- seq_err  output  1  sticky sequence error (optional feature)

Behaviour:
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE; prev_cnt and thr_q reset to 0.
- prev_cnt <= counter_in every cycle. Wrap condition: prev_cnt == all-ones and counter_in == 0.
- wrap_pulse asserts the cycle after the wrap condition is sampled (1-cycle latency). It fires in all states.
- FSM states: IDLE, ARMED, RUN, DONE.
  - IDLE: arm=1 -> ARMED; latch thr_q <= threshold; clear wrap_count, seq_err.
  - ARMED: enable=1 -> RUN, else stay.
  - RUN: on wrap condition, wrap_count <= wrap_count+1.
    - If the incremented value == TARGET_WRAPS, go to DONE; that wrap's wrap_pulse and done rise on the same edge.
    - enable=0 in RUN holds state (pause), no exit.
  - DONE: done=1 held. arm=1 -> ARMED with fresh thr_q; clears wrap_count, seq_err. Otherwise stay.
- arm while ARMED or RUN is ignored: no relatch, no clear.
- match_pulse only in RUN:
  - Asserts the cycle after counter_in == thr_q is sampled while prev_cnt != thr_q (edge into equality).
  - A held value while enable=0 gives one pulse only.
  - A match on the same sample as the final wrap still pulses.
- wrap_count never exceeds TARGET_WRAPS. It saturates at 2^WRAP_W-1 as a guard.
- busy = (state==ARMED || state==RUN), registered alongside state.
- Reset mid-run: next edge returns to IDLE, all outputs 0, partial counts discarded.
- Simultaneous reset and arm: reset wins.

Optional Feature:
- Macro: COUNT_WRAP_MONITOR_SEQ_CHECK_EN.
- With the macro: register en_d <= enable. In RUN, expected = prev_cnt + en_d (mod 2^CNT_W).
  - If counter_in != expected, seq_err <= 1 the next cycle.
  - Sticky until arm is accepted or reset.
  - The check is suppressed on the first RUN cycle (ARMED->RUN transition).
- Without the macro: no en_d or check logic; seq_err tied to 0.

Decomposition:
- Shared package counter_pkg:
  - CNT_W default constant.
  - FSM state encoding localparams: IDLE=2'd0, ARMED=2'd1, RUN=2'd2, DONE=2'd3.
  - CNT_MAX constant (all-ones).
- One sub-module: wrap_detect, which holds the prev_cnt register and produces the combinational wrap and equality-edge flags. It is reused by later stages.

Test Plan:
- Reset then idle: reset high 2 cycles, counter stepping 0..F -> all outputs 0; wrap_pulse still pulses once at the F->0 transition.
- Basic run: arm with threshold=4'h5, enable=1 continuous, TARGET_WRAPS=4.
  - Expected: busy the cycle after arm; match_pulse once per pass through 5 (4 pulses).
  - wrap_count goes 1,2,3,4; done rises with the 4th wrap_pulse; busy falls.
- Pause: enable=0 for 7 cycles with counter held at 5 -> exactly one match_pulse, state stays RUN, wrap_count unchanged.
- Re-arm from DONE: arm with threshold=4'hF -> wrap_count clears to 0, done drops, new run completes after 4 more wraps; arm pulsed mid-RUN is ignored.
- Reset mid-run: assert reset at wrap_count=2 -> next cycle all outputs 0, state IDLE; a later arm starts from 0.
- Sequence check (macro defined): force counter_in to jump 3->7 with enable=1 in RUN -> seq_err=1 next cycle, stays high through DONE, clears on the next accepted arm. Without the macro, seq_err stays 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and FSM encoding for counter-side stages.
// Used by count_wrap_monitor and wrap_detect.
package counter_pkg;

  localparam int DEF_CNT_W = 4;
  localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/wrap_detect.sv
// Holds the previous counter sample and flags the F->0 wrap
// and the rising edge into equality with a threshold.
module wrap_detect
  import counter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] counter_in,
  input  logic [CNT_W-1:0] thr,
  output logic [CNT_W-1:0] prev_cnt,
  output logic             wrap,
  output logic             eq_edge
);

  always_ff @(posedge clock) begin
    if (reset) prev_cnt <= '0;
    else       prev_cnt <= counter_in;
  end

  assign wrap    = (prev_cnt == {CNT_W{1'b1}})
                && (counter_in == '0);
  assign eq_edge = (counter_in == thr)
                && (prev_cnt != thr);

endmodule

// File: rtl/count_wrap_monitor.sv
// Wrap/threshold monitor after the free-running counter.
// Optional sequence check: COUNT_WRAP_MONITOR_SEQ_CHECK_EN.
module count_wrap_monitor
  import counter_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int WRAP_W       = 8,
  parameter int TARGET_WRAPS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              arm,
  input  logic [CNT_W-1:0]  threshold,
  output logic              busy,
  output logic              match_pulse,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              done,
  output logic              seq_err
);

  state_t state, state_n;
  logic [CNT_W-1:0]  thr_q, thr_n, prev_cnt;
  logic [WRAP_W-1:0] cnt_n, cnt_inc;
  logic wrap, eq_edge, err_n, seq_bad;

  wrap_detect #(.CNT_W(CNT_W)) u_det (
    .clock      (clock),
    .reset      (reset),
    .counter_in (counter_in),
    .thr        (thr_q),
    .prev_cnt   (prev_cnt),
    .wrap       (wrap),
    .eq_edge    (eq_edge)
  );

`ifdef COUNT_WRAP_MONITOR_SEQ_CHECK_EN
  logic en_d, run_first;
  logic [CNT_W-1:0] expected;

  always_ff @(posedge clock) begin
    if (reset) begin
      en_d      <= 1'b0;
      run_first <= 1'b0;
    end else begin
      en_d      <= enable;
      run_first <= (state == ARMED)
                && (state_n == RUN);
    end
  end

  assign expected = prev_cnt + CNT_W'(en_d);
  assign seq_bad  = !run_first
                 && (counter_in != expected);
`else
  assign seq_bad = 1'b0;
`endif

  // saturating guard; TARGET_WRAPS normally stops us first
  assign cnt_inc = (wrap_count == '1) ? wrap_count
                 : wrap_count + 1'b1;

  always_comb begin
    state_n = state;
    thr_n   = thr_q;
    cnt_n   = wrap_count;
    err_n   = seq_err;
    unique case (state)
      IDLE, DONE: begin
        if (arm) begin
          state_n = ARMED;
          thr_n   = threshold;
          cnt_n   = '0;
          err_n   = 1'b0;
        end
      end
      ARMED: begin
        if (enable) state_n = RUN;
      end
      RUN: begin
        if (wrap) begin
          cnt_n = cnt_inc;
          if (cnt_inc == WRAP_W'(TARGET_WRAPS))
            state_n = DONE;
        end
        if (seq_bad) err_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      thr_q       <= '0;
      wrap_count  <= '0;
      seq_err     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      thr_q       <= thr_n;
      wrap_count  <= cnt_n;
      seq_err     <= err_n;
      busy        <= (state_n == ARMED)
                  || (state_n == RUN);
      done        <= (state_n == DONE);
      wrap_pulse  <= wrap;
      match_pulse <= (state == RUN) && eq_edge;
    end
  end

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor with a stepping
// counter model; seq checks follow the build macro.
module tb_count_wrap_monitor;

`ifdef COUNT_WRAP_MONITOR_SEQ_CHECK_EN
  localparam logic SEQ_EXP = 1'b1;
`else
  localparam logic SEQ_EXP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, enable, arm;
  logic [3:0] counter_in, threshold;
  logic       busy, match_pulse, wrap_pulse;
  logic       done, seq_err;
  logic [7:0] wrap_count;

  int total = 0;
  int bad   = 0;
  int wp_n, mp_n, n;

  always #5 clock = ~clock;

  count_wrap_monitor #(
    .CNT_W(4), .WRAP_W(8), .TARGET_WRAPS(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .counter_in  (counter_in),
    .arm         (arm),
    .threshold   (threshold),
    .busy        (busy),
    .match_pulse (match_pulse),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count),
    .done        (done),
    .seq_err     (seq_err)
  );

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%b want=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag,
                      input int obs,
                      input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // one clock; upstream counter advances if enable was high
  task automatic cyc();
    logic e;
    e = enable;
    @(posedge clock);
    #1;
    if (e) counter_in = counter_in + 4'd1;
    wp_n += int'(wrap_pulse);
    mp_n += int'(match_pulse);
  endtask

  task automatic run(input int k);
    repeat (k) cyc();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; arm = 1'b0;
    counter_in = 4'd0; threshold = 4'd0;
    wp_n = 0; mp_n = 0;

    run(2);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chkn("rst_wcnt", int'(wrap_count), 0);
    chk1("rst_wp", wrap_pulse, 1'b0);
    chk1("rst_mp", match_pulse, 1'b0);
    chk1("rst_seq", seq_err, 1'b0);

    reset = 1'b0; wp_n = 0; mp_n = 0;
    run(16);
    chkn("idle_wraps", wp_n, 1);
    chkn("idle_match", mp_n, 0);
    chk1("idle_busy", busy, 1'b0);
    chkn("idle_wcnt", int'(wrap_count), 0);

    enable = 1'b0; arm = 1'b1; threshold = 4'h5;
    cyc();
    arm = 1'b0;
    chk1("arm_busy", busy, 1'b1);
    chkn("arm_wcnt", int'(wrap_count), 0);
    chk1("arm_done", done, 1'b0);

    counter_in = 4'd0; enable = 1'b1;
    wp_n = 0; mp_n = 0;
    run(5);
    chk1("run_busy", busy, 1'b1);
    enable = 1'b0;
    run(7);
    chkn("pause_match", mp_n, 1);
    chk1("pause_busy", busy, 1'b1);
    chkn("pause_wcnt", int'(wrap_count), 0);
    chkn("pause_cnt", int'(counter_in), 5);

    enable = 1'b1; n = 0;
    while (!done && n < 100) begin
      cyc(); n++;
      if (wrap_pulse)
        chkn("wcnt_step", int'(wrap_count), wp_n);
    end
    chkn("run_len", n, 60);
    chkn("run_wraps", wp_n, 4);
    chkn("run_match", mp_n, 4);
    chk1("done_wp", wrap_pulse, 1'b1);
    chk1("done_busy", busy, 1'b0);
    chkn("done_wcnt", int'(wrap_count), 4);
    chk1("done_seq", seq_err, 1'b0);

    run(3);
    chk1("done_hold", done, 1'b1);
    chkn("hold_wcnt", int'(wrap_count), 4);

    arm = 1'b1; threshold = 4'hF;
    cyc();
    arm = 1'b0;
    chk1("rearm_done", done, 1'b0);
    chk1("rearm_busy", busy, 1'b1);
    chkn("rearm_wcnt", int'(wrap_count), 0);
    wp_n = 0; mp_n = 0; n = 0;
    while (wrap_count != 8'd1 && n < 100) begin
      cyc(); n++;
    end
    chk1("w1_timeout", n < 100, 1'b1);
    arm = 1'b1; threshold = 4'h3;
    cyc();
    arm = 1'b0;
    chkn("midarm_wcnt", int'(wrap_count), 1);
    chk1("midarm_busy", busy, 1'b1);
    n = 0;
    while (!done && n < 100) begin
      cyc(); n++;
    end
    chk1("r2_timeout", n < 100, 1'b1);
    chkn("r2_wraps", wp_n, 4);
    chkn("r2_match", mp_n, 4);
    chkn("r2_wcnt", int'(wrap_count), 4);

    arm = 1'b1; threshold = 4'h5;
    cyc();
    arm = 1'b0; n = 0;
    while (wrap_count != 8'd2 && n < 100) begin
      cyc(); n++;
    end
    chk1("w2_timeout", n < 100, 1'b1);
    reset = 1'b1; arm = 1'b1;
    cyc();
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_done", done, 1'b0);
    chkn("mrst_wcnt", int'(wrap_count), 0);
    chk1("mrst_wp", wrap_pulse, 1'b0);
    chk1("mrst_mp", match_pulse, 1'b0);
    reset = 1'b0; arm = 1'b0;
    cyc();
    chk1("mrst_idle", busy, 1'b0);

    arm = 1'b1; threshold = 4'h0;
    cyc();
    arm = 1'b0;
    chkn("r3_wcnt0", int'(wrap_count), 0);
    wp_n = 0; mp_n = 0; n = 0;
    while (!done && n < 100) begin
      cyc(); n++;
    end
    chk1("r3_timeout", n < 100, 1'b1);
    chk1("r3_last_mp", match_pulse, 1'b1);
    chk1("r3_last_wp", wrap_pulse, 1'b1);
    chkn("r3_match", mp_n, 4);
    chkn("r3_wraps", wp_n, 4);

    arm = 1'b1; threshold = 4'h5;
    cyc();
    arm = 1'b0;
    run(8);
    n = 0;
    while (counter_in != 4'd3 && n < 40) begin
      cyc(); n++;
    end
    chk1("c3_timeout", n < 40, 1'b1);
    chk1("pre_jump_seq", seq_err, 1'b0);
    cyc();
    counter_in = 4'd7;
    cyc();
    chk1("jump_seq", seq_err, SEQ_EXP);
    n = 0;
    while (!done && n < 100) begin
      cyc(); n++;
    end
    chk1("r4_timeout", n < 100, 1'b1);
    chk1("done_seq_hold", seq_err, SEQ_EXP);
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    chk1("seq_clear", seq_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
